// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: width and latency defaults plus
// the transaction FSM state encoding.
package mem_pkg;

   localparam int unsigned WORD_SIZE_DEF = 16;
   localparam int unsigned READ_LAT_DEF  = 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StAck   = 2'd3
   } mem_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side bundle of the arbiter: instruction-fetch and data request ports.
// master = requesting side, slave = arbiter side.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
);

   logic                 i_req;
   logic [WORD_SIZE-1:0] i_addr;
   logic [WORD_SIZE-1:0] i_rdata;
   logic                 i_ack;

   logic                 d_req;
   logic                 d_we;
   logic [WORD_SIZE-1:0] d_addr;
   logic [WORD_SIZE-1:0] d_wdata;
   logic [WORD_SIZE-1:0] d_rdata;
   logic                 d_ack;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_rdata, i_ack, d_rdata, d_ack
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_rdata, i_ack, d_rdata, d_ack
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data ports.
// Optional feature macro: MEM_RR_ARB_EN (round-robin on contention); without
// it the data port always wins and no pointer flop exists.
module mem_arb_pick
   import mem_pkg::*;
(
`ifdef MEM_RR_ARB_EN
   input  logic clk,
   input  logic reset,
   input  logic take,
`endif
   input  logic i_req,
   input  logic d_req,
   output logic grant_valid,
   output logic grant_d
);

`ifdef MEM_RR_ARB_EN
   // 1 = the last contended grant went to data; reset value favours data
   logic last_d_q;

   // Flip the pointer whenever a contended request pair is granted
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b0;
      end else if (take && i_req && d_req) begin
         last_d_q <= ~last_d_q;
      end
   end

   // Single requester wins outright; contention goes to the port not granted last
   always_comb begin
      grant_valid = i_req | d_req;
      grant_d     = d_req & (~i_req | ~last_d_q);
   end
`else
   // Fixed priority: data over fetch
   always_comb begin
      grant_valid = i_req | d_req;
      grant_d     = d_req;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory with a
// bidirectional data bus. Reads: ISSUE, READ_LAT WAIT cycles, ACK.
// Writes: ISSUE (bus driven), ACK.
// Optional feature macro: MEM_RR_ARB_EN (round-robin grant, see mem_arb_pick).
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
   parameter int unsigned READ_LAT  = READ_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_arbiter_if.slave         bus,
   output logic                 read_m,
   output logic                 write_m,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data
);

   localparam logic [1:0] LastWait = 2'(READ_LAT - 1);

   mem_state_e           state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 gnt_d_q, gnt_d_d;  // 1 = data port owns the transaction
   logic                 we_q, we_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 rd_q, rd_d, wr_q, wr_d;
   logic                 i_ack_q, i_ack_d, d_ack_q, d_ack_d;
   logic                 pick_valid, pick_d;

   mem_arb_pick u_pick (
`ifdef MEM_RR_ARB_EN
      .clk         (clk),
      .reset       (reset),
      .take        (state_q == StIdle),
`endif
      .i_req       (bus.i_req),
      .d_req       (bus.d_req),
      .grant_valid (pick_valid),
      .grant_d     (pick_d)
   );

   // State and registered outputs; reset aborts any transaction silently
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         gnt_d_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_d_q   <= gnt_d_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
      end
   end

   // Next-state and next-output logic for the transaction FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d_d   = gnt_d_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            addr_d = '0;
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            if (pick_valid) begin
               gnt_d_d = pick_d;
               we_d    = pick_d & bus.d_we;
               addr_d  = pick_d ? bus.d_addr : bus.i_addr;
               wdata_d = bus.d_wdata;
               rd_d    = ~(pick_d & bus.d_we);
               wr_d    = pick_d & bus.d_we;
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (we_q) begin
               wr_d    = 1'b0;
               d_ack_d = gnt_d_q;
               i_ack_d = ~gnt_d_q;
               state_d = StAck;
            end else begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == LastWait) begin
               rd_d = 1'b0;
               if (gnt_d_q) begin
                  d_rdata_d = data;
               end else begin
                  i_rdata_d = data;
               end
               d_ack_d = gnt_d_q;
               i_ack_d = ~gnt_d_q;
               state_d = StAck;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StAck: begin
            addr_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign read_m      = rd_q;
   assign write_m     = wr_q;
   assign address     = addr_q;
   assign data        = wr_q ? wdata_q : 'z;
   assign bus.i_ack   = i_ack_q;
   assign bus.d_ack   = d_ack_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and random transactions against
// a transaction-level reference model, plus a READ_LAT=3 instance.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int unsigned WS  = 16;
   localparam int unsigned RL1 = 1;
   localparam int unsigned RL3 = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.WORD_SIZE(WS)) bus ();
   mem_arbiter_if #(.WORD_SIZE(WS)) bus3 ();

   wire  [WS-1:0] data;
   logic          read_m, write_m;
   logic [WS-1:0] address;
   wire  [WS-1:0] data3;
   logic          read_m3, write_m3;
   logic [WS-1:0] address3;

   mem_arbiter #(.WORD_SIZE(WS), .READ_LAT(RL1)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .read_m(read_m), .write_m(write_m), .address(address), .data(data)
   );

   mem_arbiter #(.WORD_SIZE(WS), .READ_LAT(RL3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3),
      .read_m(read_m3), .write_m(write_m3), .address(address3), .data(data3)
   );

   // Memory behind dut: combinational read while read_m, write on posedge
   logic [WS-1:0] mem [0:255];
   assign data = read_m ? mem[address[7:0]] : 'z;
   always @(posedge clk) if (write_m) mem[address[7:0]] <= data;

   // Memory behind dut3: read value is a fixed function of the address
   assign data3 = read_m3 ? (address3 ^ 16'h5A5A) : 'z;

   // Reference model state
   logic [WS-1:0] ref_mem [0:255];
   logic [WS-1:0] exp_i_rdata, exp_d_rdata;
   bit            rr_last_d;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drop_reqs();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
   endtask

   task automatic model_reset();
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      rr_last_d   = 1'b0;
   endtask

   // One transaction on a single port, observed cycle by cycle after sampling
   task automatic run_txn(input bit is_d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit drop_mid);
      int n, rd_n, wr_n, acks, oth, ack_n, both, lat;
      logic [15:0] got;
      lat = we ? 2 : int'(RL1) + 2;
      n = 0; rd_n = 0; wr_n = 0; acks = 0; oth = 0; ack_n = 0; both = 0; got = '0;
      @(negedge clk);
      if (is_d) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = addr;
      end
      while (n < 12) begin
         @(posedge clk); #1; n++;
         if (read_m) rd_n++;
         if (read_m && write_m) both++;
         if (write_m) begin
            wr_n++;
            check("wr_data", data, wdata);
         end
         if (n <= lat) check("addr_hold", address, addr);
         if (n == lat + 1) check("addr_idle", address, 16'h0);
         if (is_d ? bus.d_ack : bus.i_ack) begin
            acks++;
            ack_n = n;
            got = is_d ? bus.d_rdata : bus.i_rdata;
            drop_reqs();
         end
         if (is_d ? bus.i_ack : bus.d_ack) oth++;
         if (drop_mid && n == 2) drop_reqs();
      end
      check("ack_count", acks, 1);
      check("ack_lat", ack_n, lat);
      check("other_ack", oth, 0);
      check("rw_both", both, 0);
      check("read_m_cycles", rd_n, we ? 0 : int'(RL1) + 1);
      check("write_m_cycles", wr_n, we ? 1 : 0);
      if (we) begin
         ref_mem[addr[7:0]] = wdata;
      end else begin
         check("rdata_ack", got, ref_mem[addr[7:0]]);
         if (is_d) exp_d_rdata = ref_mem[addr[7:0]];
         else      exp_i_rdata = ref_mem[addr[7:0]];
      end
      check("i_rdata_hold", bus.i_rdata, exp_i_rdata);
      check("d_rdata_hold", bus.d_rdata, exp_d_rdata);
   endtask

   // Both ports request reads in the same cycle and hold until acked
   task automatic contend(input logic [15:0] ia, input logic [15:0] da);
      int n, acks, t_first, t_second;
      bit first_d, exp_first_d;
`ifdef MEM_RR_ARB_EN
      exp_first_d = !rr_last_d;
      rr_last_d   = exp_first_d;
`else
      exp_first_d = 1'b1;
`endif
      n = 0; acks = 0; t_first = 0; t_second = 0; first_d = 1'b0;
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = ia;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
      while (n < 20) begin
         @(posedge clk); #1; n++;
         if (bus.d_ack) begin
            acks++;
            if (acks == 1) begin first_d = 1'b1; t_first = n; end else t_second = n;
            check("cont_d_rdata", bus.d_rdata, ref_mem[da[7:0]]);
            bus.d_req = 1'b0;
         end
         if (bus.i_ack) begin
            acks++;
            if (acks == 1) begin first_d = 1'b0; t_first = n; end else t_second = n;
            check("cont_i_rdata", bus.i_rdata, ref_mem[ia[7:0]]);
            bus.i_req = 1'b0;
         end
      end
      check("cont_acks", acks, 2);
      check("cont_winner", first_d, exp_first_d);
      check("cont_t_first", t_first, int'(RL1) + 2);
      check("cont_t_second", t_second, 2 * int'(RL1) + 5);
      exp_i_rdata = ref_mem[ia[7:0]];
      exp_d_rdata = ref_mem[da[7:0]];
   endtask

   // Reset in the middle of a read (WAIT) or a write (ISSUE)
   task automatic reset_mid(input bit we);
      logic [15:0] zz, a;
      int oth;
      zz = 'z;
      a = 16'($urandom_range(0, 255));
      oth = 0;
      @(negedge clk);
      if (we) begin
         bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = a; bus.d_wdata = 16'($urandom);
         // the memory still sees write_m at the edge that applies reset
         ref_mem[a[7:0]] = bus.d_wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = a;
      end
      for (int k = 0; k < (we ? 1 : 2); k++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      drop_reqs();
      @(posedge clk); #1;
      model_reset();
      check("rst_read_m", read_m, 1'b0);
      check("rst_write_m", write_m, 1'b0);
      check("rst_address", address, 16'h0);
      check("rst_i_ack", bus.i_ack, 1'b0);
      check("rst_d_ack", bus.d_ack, 1'b0);
      check("rst_i_rdata", bus.i_rdata, 16'h0);
      check("rst_d_rdata", bus.d_rdata, 16'h0);
      check("rst_data_z", data, zz);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (bus.i_ack || bus.d_ack || read_m || write_m) oth++;
      end
      check("rst_no_activity", oth, 0);
   endtask

   initial begin
      int n, rd_n, ack_n;
      bit is_d, we, use_d;
      logic [15:0] a, got, zz;
      zz = 'z;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h23]     = 16'h6000;
      ref_mem[8'h23] = 16'h6000;

      bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
      bus3.d_addr = '0; bus3.d_wdata = '0;
      model_reset();

      // Reset state
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("init_read_m", read_m, 1'b0);
      check("init_write_m", write_m, 1'b0);
      check("init_address", address, 16'h0);
      check("init_acks", {bus.i_ack, bus.d_ack}, 2'b00);
      check("init_rdata", {bus.i_rdata, bus.d_rdata}, 32'h0);
      check("init_data_z", data, zz);
      @(negedge clk);
      reset = 1'b0;

      // Directed fetch, store and read-back
      run_txn(1'b0, 1'b0, 16'h0023, 16'h0, 1'b0);
      run_txn(1'b1, 1'b1, 16'h0080, 16'h1234, 1'b0);
      run_txn(1'b1, 1'b0, 16'h0080, 16'h0, 1'b0);
      run_txn(1'b0, 1'b0, 16'h0080, 16'h0, 1'b0);

      // Fetch request dropped during WAIT still completes exactly once
      run_txn(1'b0, 1'b0, 16'h0042, 16'h0, 1'b1);

      // Two contention rounds
      contend(16'h0011, 16'h0022);
      contend(16'h0033, 16'h0044);

      // Random single-port traffic
      for (int k = 0; k < 24; k++) begin
         is_d = 1'($urandom_range(0, 1));
         we   = is_d & 1'($urandom_range(0, 1));
         a    = 16'($urandom_range(0, 255));
         run_txn(is_d, we, a, 16'($urandom), 1'b0);
      end

      // Mid-transaction reset, then normal operation resumes
      reset_mid(1'b0);
      reset_mid(1'b1);
      run_txn(1'b0, 1'b0, 16'h0023, 16'h0, 1'b0);

      // READ_LAT=3 instance
      for (int k = 0; k < 3; k++) begin
         a = 16'($urandom_range(0, 255));
         use_d = k[0];
         @(negedge clk);
         if (use_d) begin
            bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = a;
         end else begin
            bus3.i_req = 1'b1; bus3.i_addr = a;
         end
         n = 0; rd_n = 0; ack_n = 0; got = '0;
         while (n < 15) begin
            @(posedge clk); #1; n++;
            if (read_m3) rd_n++;
            if (bus3.i_ack || bus3.d_ack) begin
               if (ack_n == 0) begin
                  ack_n = n;
                  got = use_d ? bus3.d_rdata : bus3.i_rdata;
               end
               bus3.i_req = 1'b0;
               bus3.d_req = 1'b0;
            end
         end
         check("rl3_read_m_cycles", rd_n, int'(RL3) + 1);
         check("rl3_ack_lat", ack_n, int'(RL3) + 2);
         check("rl3_rdata", got, a ^ 16'h5A5A);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
